// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
// The state encoding is exported so checkers and benches can name states.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_e;

    localparam int DEFAULT_WIDTH = 4;

    // The counter holds the values 0..WIDTH-1; the extra bit keeps WIDTH=1 legal.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational 1-bit full-subtractor cell: diff = a - b - borrow_in.
// It is the subtracting twin of the 1-bit full adder cell.
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic borrow_i,
    output logic diff_o,
    output logic borrow_o
);

    always_comb begin
        diff_o   = a_i ^ b_i ^ borrow_i;
        borrow_o = (~a_i & b_i) | (~(a_i ^ b_i) & borrow_i);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell and a borrow flop.
// It processes one bit per clock, LSB first, and produces {borrow_o, diff_o} = a - b - borrow_i.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             borrow_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output sub_state_e       state_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high. The upstream side transfers on valid_i & ready_o, and ready_o
    // is high only in IDLE. The downstream side transfers on valid_o & ready_i,
    // and valid_o is high only in DONE. While valid_o waits for ready_i, the
    // result stays stable. valid_i outside IDLE is dropped and is not queued.

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    sub_state_e       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CW-1:0]    cnt;
    logic             borrow_q;
    logic             ready_q;
    logic             cell_diff;
    logic             cell_borrow;

    full_subtractor u_cell (
        .a_i      (a_sr[0]),
        .b_i      (b_sr[0]),
        .borrow_i (borrow_q),
        .diff_o   (cell_diff),
        .borrow_o (cell_borrow)
    );

    // The result fills from the MSB side, so after WIDTH shifts bit 0 sits at the LSB.
    always_comb begin
        res_next            = res_sr >> 1;
        res_next[WIDTH-1]   = cell_diff;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= IDLE;
            ready_q  <= 1'b1;
            valid_o  <= 1'b0;
            diff_o   <= '0;
            borrow_o <= 1'b0;
            cnt      <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i) begin
                        a_sr     <= a_i;
                        b_sr     <= b_i;
                        borrow_q <= borrow_i;
                        cnt      <= '0;
                        ready_q  <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_sr     <= a_sr >> 1;
                    b_sr     <= b_sr >> 1;
                    res_sr   <= res_next;
                    borrow_q <= cell_borrow;
                    cnt      <= cnt + 1'b1;
                    if (cnt == LAST_BIT) begin
                        diff_o   <= res_next;
                        borrow_o <= cell_borrow;
                        valid_o  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_o <= 1'b0;
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign state_o = state;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and sweep bench for serial_subtractor at WIDTH = 4, 1 and 8.
// Expected results come from hand values or from a - b - borrow in WIDTH+1 bits.
module tb_serial_subtractor;
    import serial_sub_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       v4 = 0, r4i = 1, bin4 = 0, r4o, vo4, bo4;
    logic [3:0] a4 = 0, b4 = 0, d4;
    sub_state_e st4;
    logic       v1 = 0, r1i = 1, bin1 = 0, r1o, vo1, bo1;
    logic [0:0] a1 = 0, b1 = 0, d1;
    sub_state_e st1;
    logic       v8 = 0, r8i = 1, bin8 = 0, r8o, vo8, bo8;
    logic [7:0] a8 = 0, b8 = 0, d8;
    sub_state_e st8;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] exp_q[$];

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .valid_i(v4), .ready_o(r4o), .a_i(a4), .b_i(b4),
        .borrow_i(bin4), .valid_o(vo4), .ready_i(r4i), .diff_o(d4), .borrow_o(bo4),
        .state_o(st4));
    serial_subtractor #(.WIDTH(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .valid_i(v1), .ready_o(r1o), .a_i(a1), .b_i(b1),
        .borrow_i(bin1), .valid_o(vo1), .ready_i(r1i), .diff_o(d1), .borrow_o(bo1),
        .state_o(st1));
    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .valid_i(v8), .ready_o(r8o), .a_i(a8), .b_i(b8),
        .borrow_i(bin8), .valid_o(vo8), .ready_i(r8i), .diff_o(d8), .borrow_o(bo8),
        .state_o(st8));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=4 operation; noise scrambles the inputs while the block is busy.
    task automatic do_op4(input logic [3:0] a, input logic [3:0] b, input logic bin,
                          input logic [3:0] ed, input logic eb, input int stall, input bit noise);
        logic [8:0] e;
        int lat;
        exp_q.push_back({4'b0, eb, ed});
        chk("w4_ready_idle", 32'(r4o), 32'd1);
        a4 = a; b4 = b; bin4 = bin; v4 = 1'b1; r4i = (stall == 0);
        step();
        v4 = 1'b0;
        lat = 0;
        do begin
            if (noise) begin
                a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15));
                bin4 = 1'($urandom_range(0, 1)); v4 = 1'($urandom_range(0, 1));
            end
            step();
            lat++;
            chk("w4_ready_busy", 32'(r4o), 32'd0);
        end while (!vo4 && lat < 8);
        chk("w4_latency", 32'(lat), 32'd4);
        e = exp_q.pop_front();
        chk("w4_diff", 32'(d4), 32'(e[3:0]));
        chk("w4_borrow", 32'(bo4), 32'(e[4]));
        for (int s = 0; s < stall; s++) begin
            if (noise) begin
                a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15));
                v4 = 1'($urandom_range(0, 1));
            end
            step();
            chk("w4_hold_valid", 32'(vo4), 32'd1);
            chk("w4_hold_diff", 32'(d4), 32'(e[3:0]));
            chk("w4_hold_borrow", 32'(bo4), 32'(e[4]));
            chk("w4_hold_ready", 32'(r4o), 32'd0);
        end
        v4 = 1'b0;
        r4i = 1'b1;
        step();
        chk("w4_valid_drop", 32'(vo4), 32'd0);
        chk("w4_ready_back", 32'(r4o), 32'd1);
    endtask

    task automatic do_op1(input logic a, input logic b, input logic bin, input int stall);
        logic [8:0] e;
        int lat;
        exp_q.push_back(9'({2'b00, a} - {2'b00, b} - {2'b00, bin}) & 9'h3);
        chk("w1_ready_idle", 32'(r1o), 32'd1);
        a1 = a; b1 = b; bin1 = bin; v1 = 1'b1; r1i = (stall == 0);
        step();
        v1 = 1'b0;
        lat = 0;
        do begin step(); lat++; end while (!vo1 && lat < 5);
        chk("w1_latency", 32'(lat), 32'd1);
        e = exp_q.pop_front();
        chk("w1_diff", 32'(d1), 32'(e[0]));
        chk("w1_borrow", 32'(bo1), 32'(e[1]));
        for (int s = 0; s < stall; s++) step();
        chk("w1_hold_diff", 32'(d1), 32'(e[0]));
        r1i = 1'b1;
        step();
        chk("w1_valid_drop", 32'(vo1), 32'd0);
    endtask

    task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic bin, input int stall);
        logic [8:0] e;
        int lat;
        exp_q.push_back({1'b0, a} - {1'b0, b} - {8'b0, bin});
        chk("w8_ready_idle", 32'(r8o), 32'd1);
        a8 = a; b8 = b; bin8 = bin; v8 = 1'b1; r8i = (stall == 0);
        step();
        v8 = 1'b0;
        lat = 0;
        do begin step(); lat++; end while (!vo8 && lat < 12);
        chk("w8_latency", 32'(lat), 32'd8);
        e = exp_q.pop_front();
        chk("w8_diff", 32'(d8), 32'(e[7:0]));
        chk("w8_borrow", 32'(bo8), 32'(e[8]));
        for (int s = 0; s < stall; s++) step();
        chk("w8_hold_diff", 32'(d8), 32'(e[7:0]));
        r8i = 1'b1;
        step();
        chk("w8_valid_drop", 32'(vo8), 32'd0);
    endtask

    initial begin
        logic [4:0] e4;
        // Clock/reset.
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        chk("rst_ready", 32'(r4o), 32'd1);
        chk("rst_valid", 32'(vo4), 32'd0);
        chk("rst_diff", 32'(d4), 32'd0);
        chk("rst_borrow", 32'(bo4), 32'd0);
        chk("rst_state", 32'(st4), 32'(IDLE));
        step();
        chk("rst_ready_after", 32'(r4o), 32'd1);

        // Directed vectors with hand-computed results.
        do_op4(4'd9, 4'd3, 1'b0, 4'h6, 1'b0, 0, 0);
        do_op4(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 0, 0);
        do_op4(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 0, 0);
        do_op4(4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 0, 0);
        do_op4(4'd7, 4'd7, 1'b1, 4'hF, 1'b1, 0, 0);
        do_op4(4'h0, 4'hF, 1'b1, 4'h0, 1'b1, 1, 0);
        do_op4(4'hF, 4'h0, 1'b0, 4'hF, 1'b0, 0, 0);

        // Backpressure with noisy inputs while busy.
        do_op4(4'hC, 4'h5, 1'b0, 4'h7, 1'b0, 5, 1);

        // Reset during the second SHIFT cycle aborts the operation.
        a4 = 4'hA; b4 = 4'h1; bin4 = 1'b0; v4 = 1'b1; r4i = 1'b1;
        step();
        v4 = 1'b0;
        step();
        chk("abort_in_shift", 32'(st4), 32'(SHIFT));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_valid", 32'(vo4), 32'd0);
        chk("abort_ready", 32'(r4o), 32'd1);
        chk("abort_diff", 32'(d4), 32'd0);
        chk("abort_state", 32'(st4), 32'(IDLE));
        for (int i = 0; i < 6; i++) begin
            step();
            chk("abort_no_valid", 32'(vo4), 32'd0);
        end
        do_op4(4'd5, 4'd2, 1'b0, 4'h3, 1'b0, 0, 0);

        // Exhaustive WIDTH=4 sweep with random stalls.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    e4 = {1'b0, 4'(a)} - {1'b0, 4'(b)} - 5'(c);
                    do_op4(4'(a), 4'(b), 1'(c), e4[3:0], e4[4], $urandom_range(0, 2), 0);
                end

        // WIDTH=1: every combination, with and without stalls.
        for (int k = 0; k < 16; k++)
            do_op1(k[0], k[1], k[2], k[3] ? 2 : 0);

        // WIDTH=8: boundaries, then random operands.
        do_op8(8'h00, 8'hFF, 1'b1, 0);
        do_op8(8'hFF, 8'hFF, 1'b0, 1);
        do_op8(8'h80, 8'h7F, 1'b1, 0);
        for (int k = 0; k < 200; k++)
            do_op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                   1'($urandom_range(0, 1)), $urandom_range(0, 2));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
